// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module   : des_pkg
// Purpose  : DES key-schedule constants, permutation tables and shift helper.
// Revision : 1.0
// ============================================================================
package des_pkg;

  localparam int DES_ROUNDS = 16;

  typedef logic [1:64] des_key_t;
  typedef logic [1:56] des_cd_t;
  typedef logic [1:48] des_subkey_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } des_state_t;

  // Entry i names the key bit (1 = MSB) that lands in C|D bit i.
  localparam int PC1 [1:56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [1:48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [1:0] des_shift(input logic [4:0] k);
    return (k == 5'd1 || k == 5'd2 || k == 5'd9 || k == 5'd16) ? 2'd1 : 2'd2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/des_pc2.sv
`default_nettype none
// ============================================================================
// Module   : des_pc2
// Purpose  : DES Permuted Choice 2, pure wiring from 56-bit C|D to a subkey.
// Revision : 1.0
// ============================================================================
module des_pc2
  import des_pkg::*;
(
  input  logic [1:56] cd,
  output logic [1:48] subkey
);

  for (genvar i = 1; i <= 48; i++) begin : g_pc2
    assign subkey[i] = cd[PC2[i]];
  end

  // PC-2 drops these eight C|D positions by definition.
  logic w_unused_cd;
  assign w_unused_cd = ^{cd[9], cd[18], cd[22], cd[25],
                         cd[35], cd[38], cd[43], cd[54]};

endmodule
`default_nettype wire

// File: rtl/des_subkey_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : des_subkey_sequencer
// Purpose  : Iterative DES key schedule streaming 16 subkeys, enc or dec order.
// Revision : 1.0
// ============================================================================
module des_subkey_sequencer
  import des_pkg::*;
#(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [1:64] key_in,
  input  logic        decrypt,
  input  logic        flush,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic [1:48] sk_data,
  output logic [4:0]  sk_round,
  output logic        sk_last,
  output logic        busy
);

  if (ROUNDS != DES_ROUNDS) begin : g_rounds_check
    $error("des_subkey_sequencer: ROUNDS must be 16");
  end

  localparam logic [4:0] c_last_round = 5'(DES_ROUNDS);

  function automatic logic [1:28] rotl28(input logic [1:28] v, input logic [1:0] n);
    return (n == 2'd2) ? {v[3:28], v[1:2]} : {v[2:28], v[1]};
  endfunction

  function automatic logic [1:28] rotr28(input logic [1:28] v, input logic [1:0] n);
    return (n == 2'd2) ? {v[27:28], v[1:26]} : {v[28], v[1:27]};
  endfunction

  des_state_t  r_state, w_state_nxt;
  des_cd_t     r_cd, w_cd_nxt;
  logic [4:0]  r_round, w_round_nxt;
  logic        r_decrypt, w_decrypt_nxt;
  des_cd_t     w_pc1;
  logic        w_last;
  logic [1:0]  w_enc_shift;
  logic [1:0]  w_dec_shift;

  for (genvar i = 1; i <= 56; i++) begin : g_pc1
    assign w_pc1[i] = key_in[PC1[i]];
  end

  // Parity bits never reach C|D.
  logic w_unused_parity;
  assign w_unused_parity = ^{key_in[8], key_in[16], key_in[24], key_in[32],
                             key_in[40], key_in[48], key_in[56], key_in[64]};

  assign w_last      = (r_state == ST_RUN) &&
                       (r_decrypt ? (r_round == 5'd1) : (r_round == c_last_round));
  assign w_enc_shift = des_shift(r_round + 5'd1);
  assign w_dec_shift = des_shift(r_round);

  always_comb begin
    w_state_nxt   = r_state;
    w_cd_nxt      = r_cd;
    w_round_nxt   = r_round;
    w_decrypt_nxt = r_decrypt;
    case (r_state)
      ST_IDLE: begin
        if (flush) begin
          w_cd_nxt    = '0;
          w_round_nxt = 5'd0;
        end else if (key_valid) begin
          w_state_nxt   = ST_RUN;
          w_decrypt_nxt = decrypt;
          if (decrypt) begin
            // Total rotation is 28, so C16|D16 equals C0|D0.
            w_cd_nxt    = w_pc1;
            w_round_nxt = c_last_round;
          end else begin
            w_cd_nxt    = {rotl28(w_pc1[1:28], 2'd1), rotl28(w_pc1[29:56], 2'd1)};
            w_round_nxt = 5'd1;
          end
        end
      end
      ST_RUN: begin
        if (flush || (sk_ready && w_last)) begin
          w_state_nxt = ST_IDLE;
          w_cd_nxt    = '0;
          w_round_nxt = 5'd0;
        end else if (sk_ready) begin
          if (r_decrypt) begin
            w_cd_nxt    = {rotr28(r_cd[1:28], w_dec_shift), rotr28(r_cd[29:56], w_dec_shift)};
            w_round_nxt = r_round - 5'd1;
          end else begin
            w_cd_nxt    = {rotl28(r_cd[1:28], w_enc_shift), rotl28(r_cd[29:56], w_enc_shift)};
            w_round_nxt = r_round + 5'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cd_nxt    = '0;
        w_round_nxt = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cd      <= '0;
      r_round   <= 5'd0;
      r_decrypt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cd      <= w_cd_nxt;
      r_round   <= w_round_nxt;
      r_decrypt <= w_decrypt_nxt;
    end
  end

  des_pc2 u_pc2 (
    .cd     (r_cd),
    .subkey (sk_data)
  );

  assign key_ready = (r_state == ST_IDLE);
  assign sk_valid  = (r_state == ST_RUN);
  assign busy      = (r_state == ST_RUN);
  assign sk_round  = r_round;
  assign sk_last   = w_last;

endmodule
`default_nettype wire

// File: tb/tb_des_subkey_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_subkey_sequencer
// Purpose  : Directed self-checking bench for the DES subkey sequencer.
// Revision : 1.0
// ============================================================================
module tb_des_subkey_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic        decrypt = 1'b0;
  logic        flush = 1'b0;
  logic        sk_ready = 1'b0;
  logic [1:64] key_in = '0;
  logic        key_ready, sk_valid, sk_last, busy;
  logic [1:48] sk_data;
  logic [4:0]  sk_round;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] KEY_A     = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_ONES  = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [47:0] ALL_ONES  = 48'hFFFFFFFFFFFF;

  logic [47:0] exp_k [1:16];
  logic [47:0] got_data [0:31];
  logic [4:0]  got_round [0:31];
  logic        got_last [0:31];
  int          got_n;
  int          got_cycles;
  int          stall_bad;

  always #5 clk = ~clk;

  des_subkey_sequencer #(.ROUNDS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .decrypt   (decrypt),
    .flush     (flush),
    .sk_valid  (sk_valid),
    .sk_ready  (sk_ready),
    .sk_data   (sk_data),
    .sk_round  (sk_round),
    .sk_last   (sk_last),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [63:0] k, input logic dec);
    int t = 0;
    key_in    = k;
    decrypt   = dec;
    key_valid = 1'b1;
    while (key_ready !== 1'b1 && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) begin
      n_checks++; n_fail++;
      $display("FAIL key_accept_timeout key_ready=%b required 1", key_ready);
    end
    step();
    key_valid = 1'b0;
  endtask

  // Records accepted beats; optionally presents a foreign key mid-run.
  task automatic collect(input int ready_pct, input bit inject);
    logic [1:48] held;
    logic [4:0]  held_r;
    bit          stalled = 1'b0;
    int          t = 0;
    got_n = 0;
    stall_bad = 0;
    while (t < 400) begin
      if (stalled && (sk_valid !== 1'b1 || sk_data !== held || sk_round !== held_r))
        stall_bad++;
      if (inject && t == 3) begin
        key_in = '0; decrypt = 1'b1; key_valid = 1'b1;
      end
      if (inject && t == 10) key_valid = 1'b0;
      sk_ready = ($urandom_range(0, 99) < ready_pct);
      stalled  = (sk_valid === 1'b1) && !sk_ready;
      held     = sk_data;
      held_r   = sk_round;
      if (sk_valid === 1'b1 && sk_ready) begin
        got_data[got_n]  = sk_data;
        got_round[got_n] = sk_round;
        got_last[got_n]  = sk_last;
        got_n++;
      end
      step();
      t++;
      if (got_n >= 32 || (got_n > 0 && got_last[got_n-1] === 1'b1)) break;
    end
    got_cycles = t;
    sk_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({key_ready, sk_valid, sk_last, busy} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags got kr/v/l/b=%b required 1000", {key_ready, sk_valid, sk_last, busy});
    end
    n_checks++;
    if (sk_data !== 48'h0 || sk_round !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_data got data=%h round=%0d required 0/0", sk_data, sk_round);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_encrypt();
    send_key(KEY_A, 1'b0);
    n_checks++;
    if (sk_valid !== 1'b1 || sk_round !== 5'd1 || sk_data !== exp_k[1]) begin
      n_fail++;
      $display("FAIL enc_first_beat got v=%b r=%0d d=%h required 1/1/%h", sk_valid, sk_round, sk_data, exp_k[1]);
    end
    collect(100, 1'b0);
    n_checks++;
    if (got_n !== 16 || got_cycles !== 16) begin
      n_fail++;
      $display("FAIL enc_count got beats=%0d cycles=%0d required 16/16", got_n, got_cycles);
    end
    for (int i = 0; i < 16 && i < got_n; i++) begin
      n_checks++;
      if (got_data[i] !== exp_k[i+1] || got_round[i] !== 5'(i+1) || got_last[i] !== (i == 15)) begin
        n_fail++;
        $display("FAIL enc_beat%0d got d=%h r=%0d l=%b required %h/%0d/%b", i+1, got_data[i], got_round[i], got_last[i], exp_k[i+1], i+1, i == 15);
      end
    end
    n_checks++;
    if (key_ready !== 1'b1 || sk_valid !== 1'b0 || busy !== 1'b0 || sk_data !== 48'h0) begin
      n_fail++;
      $display("FAIL enc_after got kr=%b v=%b b=%b d=%h required 1/0/0/0", key_ready, sk_valid, busy, sk_data);
    end
  endtask

  task automatic test_decrypt();
    send_key(KEY_A, 1'b1);
    collect(100, 1'b0);
    n_checks++;
    if (got_n !== 16) begin
      n_fail++;
      $display("FAIL dec_count got %0d required 16", got_n);
    end
    for (int i = 0; i < 16 && i < got_n; i++) begin
      n_checks++;
      if (got_data[i] !== exp_k[16-i] || got_round[i] !== 5'(16-i) || got_last[i] !== (i == 15)) begin
        n_fail++;
        $display("FAIL dec_beat%0d got d=%h r=%0d l=%b required %h/%0d/%b", i+1, got_data[i], got_round[i], got_last[i], exp_k[16-i], 16-i, i == 15);
      end
    end
  endtask

  task automatic test_backpressure();
    send_key(KEY_A, 1'b0);
    collect(50, 1'b1);
    n_checks++;
    if (stall_bad !== 0 || got_n !== 16) begin
      n_fail++;
      $display("FAIL bp_stall got unstable=%0d beats=%0d required 0/16", stall_bad, got_n);
    end
    for (int i = 0; i < 16 && i < got_n; i++) begin
      n_checks++;
      if (got_data[i] !== exp_k[i+1] || got_round[i] !== 5'(i+1)) begin
        n_fail++;
        $display("FAIL bp_beat%0d got d=%h r=%0d required %h/%0d", i+1, got_data[i], got_round[i], exp_k[i+1], i+1);
      end
    end
    n_checks++;
    if (key_ready !== 1'b1 || sk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_after got kr=%b v=%b required 1/0", key_ready, sk_valid);
    end
  endtask

  task automatic test_back_to_back();
    send_key(KEY_A, 1'b0);
    key_in = KEY_ONES; decrypt = 1'b0; key_valid = 1'b1;
    collect(100, 1'b0);
    n_checks++;
    if (got_n !== 16 || got_data[0] !== exp_k[1] || got_data[15] !== exp_k[16]) begin
      n_fail++;
      $display("FAIL b2b_first_stream got n=%0d k1=%h k16=%h required 16/%h/%h", got_n, got_data[0], got_data[15], exp_k[1], exp_k[16]);
    end
    n_checks++;
    if (key_ready !== 1'b1 || sk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap got kr=%b v=%b required 1/0", key_ready, sk_valid);
    end
    step();
    key_valid = 1'b0;
    n_checks++;
    if (sk_valid !== 1'b1 || sk_round !== 5'd1 || sk_data !== ALL_ONES) begin
      n_fail++;
      $display("FAIL b2b_second_k1 got v=%b r=%0d d=%h required 1/1/%h", sk_valid, sk_round, sk_data, ALL_ONES);
    end
    collect(100, 1'b0);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (i >= got_n || got_data[i] !== ALL_ONES) begin
        n_fail++;
        $display("FAIL b2b_second_beat%0d got n=%0d d=%h required %h", i+1, got_n, got_data[i], ALL_ONES);
      end
    end
  endtask

  task automatic test_flush();
    send_key(KEY_A, 1'b0);
    sk_ready = 1'b1;
    repeat (4) step();
    n_checks++;
    if (sk_round !== 5'd5 || sk_data !== exp_k[5]) begin
      n_fail++;
      $display("FAIL flush_beat5 got r=%0d d=%h required 5/%h", sk_round, sk_data, exp_k[5]);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    sk_ready = 1'b0;
    n_checks++;
    if (sk_valid !== 1'b0 || key_ready !== 1'b1 || sk_data !== 48'h0 || sk_round !== 5'd0) begin
      n_fail++;
      $display("FAIL flush_after got v=%b kr=%b d=%h r=%0d required 0/1/0/0", sk_valid, key_ready, sk_data, sk_round);
    end
    key_in = KEY_A; decrypt = 1'b0; key_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++;
    if (sk_valid !== 1'b0 || key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_drops_key got v=%b kr=%b required 0/1", sk_valid, key_ready);
    end
    step();
    key_valid = 1'b0;
    n_checks++;
    if (sk_valid !== 1'b1 || sk_round !== 5'd1 || sk_data !== exp_k[1]) begin
      n_fail++;
      $display("FAIL flush_restart got v=%b r=%0d d=%h required 1/1/%h", sk_valid, sk_round, sk_data, exp_k[1]);
    end
    collect(100, 1'b0);
    n_checks++;
    if (got_n !== 16 || got_data[15] !== exp_k[16]) begin
      n_fail++;
      $display("FAIL flush_restart_stream got n=%0d k16=%h required 16/%h", got_n, got_data[15], exp_k[16]);
    end
  endtask

  task automatic test_async_reset();
    // Parity-flipped copy of KEY_A must yield the same schedule.
    send_key(KEY_A ^ 64'h0101010101010101, 1'b0);
    sk_ready = 1'b1;
    repeat (7) step();
    n_checks++;
    if (sk_round !== 5'd8 || sk_data !== exp_k[8]) begin
      n_fail++;
      $display("FAIL rst_beat8 got r=%0d d=%h required 8/%h", sk_round, sk_data, exp_k[8]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({key_ready, sk_valid, sk_last, busy} !== 4'b1000 || sk_data !== 48'h0 || sk_round !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_immediate got kr/v/l/b=%b d=%h r=%0d required 1000/0/0", {key_ready, sk_valid, sk_last, busy}, sk_data, sk_round);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    step();
    sk_ready = 1'b0;
    n_checks++;
    if (sk_valid !== 1'b0 || key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_release got v=%b kr=%b required 0/1", sk_valid, key_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_k[1]  = 48'h1B02EFFC7072; exp_k[2]  = 48'h79AED9DBC9E5;
    exp_k[3]  = 48'h55FC8A42CF99; exp_k[4]  = 48'h72ADD6DB351D;
    exp_k[5]  = 48'h7CEC07EB53A8; exp_k[6]  = 48'h63A53E507B2F;
    exp_k[7]  = 48'hEC84B7F618BC; exp_k[8]  = 48'hF78A3AC13BFB;
    exp_k[9]  = 48'hE0DBEBEDE781; exp_k[10] = 48'hB1F347BA464F;
    exp_k[11] = 48'h215FD3DED386; exp_k[12] = 48'h7571F59467E9;
    exp_k[13] = 48'h97C5D1FABA41; exp_k[14] = 48'h5F43B7F2E73A;
    exp_k[15] = 48'hBF918D3D3F0A; exp_k[16] = 48'hCB3D8B0E17F5;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
